fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
- Instruction-fetch front end feeding the decode stage.
- Owns the fetch PC and issues word requests to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions with their PCs in a small FIFO, so a decode stall does not lose fetched words.
- Flushes and redirects on a taken branch or jump signalled from execute (PCsrc_E / PCTarget_E).

Parameters:
WIDTH, 32, datapath/PC width
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 32'h00000000, first fetch address after reset

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
PCsrc_E  input  1  redirect request from execute (taken branch/jump)
PCTarget_E  input  WIDTH  redirect target; bits [1:0] ignored (treated as 0)
stall_D  input  1  decode cannot accept the head instruction this cycle
imem_req  output  1  read request to instruction memory this cycle
imem_addr  output  WIDTH  word address of request (= fetch PC)
imem_rdata  input  WIDTH  instruction, valid the cycle after a request
valid_D  output  1  head entry present
instr_D  output  WIDTH  head instruction
PC_D  output  WIDTH  PC of head instruction
PCPlus4_D  output  WIDTH  PC_D + 4 (mod 2^WIDTH)

Behaviour:
- One clock, clk; reset rst is synchronous and active-high.
- State:
  - fetch PC (fpc)
  - FIFO of DEPTH {instr, pc} entries, with wrapping read/write pointers and count 0..DEPTH
  - inflight bit plus inflight PC (request issued last cycle)
- Reset (rst=1 at edge):
  - fpc := RESET_PC; count, pointers, inflight := 0.
  - While rst=1: imem_req=0 and imem_addr=RESET_PC.
  - imem_rdata in the cycle after reset is ignored because inflight=0.
- Issue:
  - imem_req = !rst && !PCsrc_E && (count + inflight < DEPTH); imem_addr = fpc.
  - On issue: fpc := fpc + 4 (wraps 0xFFFFFFFC -> 0); inflight := 1 with inflight PC = fpc. Otherwise inflight := 0.
  - The count + inflight <= DEPTH invariant guarantees no overflow. There is no pop credit: issue is conservative.
- Response: in a cycle with inflight=1 and PCsrc_E=0, {imem_rdata, inflight PC} is enqueued at the edge.
- Latency: request in cycle t; data in t+1; visible on the D outputs at t+2 (no bypass).
- Output/pop:
  - valid_D = (count != 0).
  - Head fields are driven combinationally from FIFO storage.
  - When valid_D=0: instr_D = 32'h00000013 (NOP), PC_D = 0, PCPlus4_D = 4.
  - Pop at the edge when valid_D && !stall_D && !PCsrc_E.
- Simultaneous enqueue and pop: count unchanged; both pointers advance.
- Empty with stall_D=1: no effect. Full with stall_D=1: hold all entries; imem_req=0.
- Redirect (PCsrc_E=1 in cycle t):
  - imem_req=0 in cycle t.
  - The response arriving in cycle t is discarded.
  - At the edge: FIFO cleared, inflight := 0, fpc := {PCTarget_E[WIDTH-1:2], 2'b00}.
  - Consequences: valid_D=0 in t+1; request to target in t+1; target visible at t+3.
  - Redirect overrides stall_D and pop.
- Back-to-back redirects: each one wins. The last target is fetched.
- Reset during redirect: reset wins.
- Steady state with stall_D=0: one instruction per cycle on the D outputs.

Test Plan:
- Reset release, stall_D=0, imem returns mem[addr>>2]=addr|0xA000 -> imem_req=1 with addr 0 in the first post-reset cycle; valid_D first high two cycles later with PC_D=0, instr_D=0xA000, PCPlus4_D=4; then PC_D=4, 8, 12 on consecutive cycles.
- stall_D=1 held 10 cycles from reset -> exactly 4 requests issued (addr 0..12), imem_req then 0, count=4, head PC_D=0 throughout; release -> PC_D 0, 4, 8, 12, 16 consecutively with no gap after 12 beyond issue latency and no duplicates.
- Queue holding PCs 0x20, 0x24, 0x28 with a request in flight; pulse PCsrc_E=1, PCTarget_E=0x103 -> imem_req=0 that cycle; valid_D=0 next cycle; imem_addr=0x100 next cycle; PC_D=0x100 three cycles after the pulse; 0x20..0x2C never reappear.
- PCsrc_E=1 and stall_D=1 in the same cycle with a full FIFO -> FIFO flushed; fetch restarts at target; stall has no effect on the flush.
- RESET_PC=0xFFFFFFF8, stall_D=0 -> PC_D sequence FFFFFFF8, FFFFFFFC, 00000000, 00000004; PCPlus4_D for FFFFFFFC is 00000000.
- Assert rst for one cycle while a request is in flight and the FIFO holds 2 entries -> next cycle valid_D=0, imem_rdata ignored, fetch restarts at RESET_PC; no pre-reset PC ever appears on PC_D.

Source files
------------

// File: rtl/fetch_buffer.sv
// Instruction-fetch front end. Owns the fetch PC, issues word reads to a
// synchronous instruction memory with 1-cycle latency, and queues the returned
// {instr, pc} pairs in a small FIFO so a decode stall never drops a fetched word.
// A taken branch/jump from execute (PCsrc_E) flushes the queue and redirects fetch.
module fetch_buffer #(
  parameter int unsigned     WIDTH    = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCsrc_E,
  input  logic [WIDTH-1:0] PCTarget_E,
  input  logic             stall_D,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             valid_D,
  output logic [WIDTH-1:0] instr_D,
  output logic [WIDTH-1:0] PC_D,
  output logic [WIDTH-1:0] PCPlus4_D
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  // Occupancy (count + inflight) needs one extra bit so DEPTH itself is representable.
  localparam logic [CntW:0]    DepthOcc = (CntW + 1)'(DEPTH);
  localparam logic [WIDTH-1:0] Nop      = WIDTH'(32'h0000_0013);
  localparam logic [WIDTH-1:0] Four     = WIDTH'(4);

  // Fetch-side state
  logic [WIDTH-1:0] fpc_q, fpc_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] inflight_pc_q, inflight_pc_d;

  // Queue state
  logic [WIDTH-1:0] instr_mem_q [DEPTH];
  logic [WIDTH-1:0] pc_mem_q    [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  logic [CntW:0] occupancy;
  logic          issue;
  logic          enq;
  logic          pop;
  logic          head_valid;

  // The low target bits are architecturally ignored.
  logic unused_target_bits;
  assign unused_target_bits = ^PCTarget_E[1:0];

  // Control decode: issue only while every slot (including the one in flight) has room.
  always_comb begin
    occupancy  = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
    issue      = !rst && !PCsrc_E && (occupancy < DepthOcc);
    enq        = inflight_q && !PCsrc_E;
    head_valid = (count_q != '0);
    pop        = head_valid && !stall_D && !PCsrc_E;
  end

  // Fetch PC and in-flight tracking; a redirect wins over a normal increment.
  always_comb begin
    fpc_d         = fpc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (PCsrc_E) begin
      fpc_d = {PCTarget_E[WIDTH-1:2], 2'b00};
    end else if (issue) begin
      fpc_d         = fpc_q + Four;
      inflight_d    = 1'b1;
      inflight_pc_d = fpc_q;
    end
  end

  // Queue pointers and count; a redirect empties the queue outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (PCsrc_E) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({enq, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q         <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fpc_q         <= fpc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Queue storage: capture the memory response together with the PC it was fetched from.
  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  // Memory request and decode-side outputs; empty queue presents a NOP at PC 0.
  always_comb begin
    imem_req  = issue;
    imem_addr = rst ? RESET_PC : fpc_q;
    valid_D   = head_valid;
    instr_D   = head_valid ? instr_mem_q[rd_ptr_q] : Nop;
    PC_D      = head_valid ? pc_mem_q[rd_ptr_q] : '0;
    PCPlus4_D = PC_D + Four;
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: a cycle table for the main flow plus
// hand-written sequences for stall fill/drain, flush under stall, reset mid-flight
// and PC wrap-around (second instance with a high reset PC).
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCsrc_E = 1'b0;
  logic [31:0] PCTarget_E = '0;
  logic        stall_D = 1'b0;

  logic        req1, valid1, req2, valid2;
  logic [31:0] addr1, instr1, pc1, p41, addr2, instr2, pc2, p42;
  logic [31:0] rdata1 = '0;
  logic [31:0] rdata2 = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_buffer #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .PCsrc_E(PCsrc_E), .PCTarget_E(PCTarget_E), .stall_D(stall_D),
    .imem_req(req1), .imem_addr(addr1), .imem_rdata(rdata1),
    .valid_D(valid1), .instr_D(instr1), .PC_D(pc1), .PCPlus4_D(p41)
  );

  fetch_buffer #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
    .clk(clk), .rst(rst), .PCsrc_E(PCsrc_E), .PCTarget_E(PCTarget_E), .stall_D(stall_D),
    .imem_req(req2), .imem_addr(addr2), .imem_rdata(rdata2),
    .valid_D(valid2), .instr_D(instr2), .PC_D(pc2), .PCPlus4_D(p42)
  );

  // Instruction memory models: mem[addr>>2] = addr | 0xA000, junk when not requested.
  always @(posedge clk) begin
    rdata1 <= req1 ? (addr1 | 32'h0000_A000) : 32'hDEAD_BEEF;
    rdata2 <= req2 ? (addr2 | 32'h0000_A000) : 32'hDEAD_BEEF;
  end

  typedef struct {
    logic        rst;
    logic        ps;
    logic [31:0] tgt;
    logic        st;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs just after a rising edge, then move to the falling edge to sample.
  task automatic cyc(input logic r, input logic ps, input logic [31:0] tgt, input logic st);
    @(posedge clk);
    #1;
    rst        = r;
    PCsrc_E    = ps;
    PCTarget_E = tgt;
    stall_D    = st;
    @(negedge clk);
  endtask

  task automatic add(input logic r, input logic ps, input logic [31:0] tgt, input logic st,
                     input logic req, input logic [31:0] addr, input logic valid,
                     input logic [31:0] pc);
    vec_t v;
    v.rst = r; v.ps = ps; v.tgt = tgt; v.st = st;
    v.req = req; v.addr = addr; v.valid = valid; v.pc = pc;
    tbl.push_back(v);
  endtask

  // Head checks on the base instance; instr is derived from the memory pattern.
  task automatic check_head(input string name, input logic v, input logic [31:0] pc);
    check({name, "_valid"}, {31'd0, valid1}, {31'd0, v});
    check({name, "_pc"}, pc1, v ? pc : 32'd0);
    check({name, "_instr"}, instr1, v ? (pc | 32'h0000_A000) : 32'h0000_0013);
    check({name, "_pcplus4"}, p41, (v ? pc : 32'd0) + 32'd4);
  endtask

  initial begin
    int nreq;

    // ---------------- table: startup, steady stream, redirects, reset-over-redirect
    add(1, 0, 0, 0, 0, 32'h000, 0, 0);           // held in reset
    add(0, 0, 0, 0, 1, 32'h000, 0, 0);           // first request to RESET_PC
    add(0, 0, 0, 0, 1, 32'h004, 0, 0);
    for (int k = 3; k <= 10; k++) add(0, 0, 0, 0, 1, 32'(4 * (k - 1)), 1, 32'(4 * (k - 3)));
    add(0, 0, 0, 1, 1, 32'h028, 1, 32'h020);     // stall: queue fills behind 0x20
    add(0, 0, 0, 1, 1, 32'h02C, 1, 32'h020);
    add(0, 1, 32'h103, 1, 0, 32'h030, 1, 32'h020); // redirect with 20,24,28 queued, 2C in flight
    add(0, 0, 0, 0, 1, 32'h100, 0, 0);
    add(0, 0, 0, 0, 1, 32'h104, 0, 0);
    add(0, 0, 0, 0, 1, 32'h108, 1, 32'h100);     // target visible three cycles after pulse
    add(0, 0, 0, 0, 1, 32'h10C, 1, 32'h104);
    add(0, 0, 0, 0, 1, 32'h110, 1, 32'h108);
    add(0, 1, 32'h200, 0, 0, 32'h114, 1, 32'h10C); // back-to-back redirects
    add(0, 1, 32'h302, 0, 0, 32'h200, 0, 0);
    add(0, 0, 0, 0, 1, 32'h300, 0, 0);
    add(0, 0, 0, 0, 1, 32'h304, 0, 0);
    add(0, 0, 0, 0, 1, 32'h308, 1, 32'h300);
    add(1, 1, 32'h400, 0, 0, 32'h000, 1, 32'h304); // reset beats redirect
    add(0, 0, 0, 0, 1, 32'h000, 0, 0);
    add(0, 0, 0, 0, 1, 32'h004, 0, 0);
    add(0, 0, 0, 0, 1, 32'h008, 1, 32'h000);

    cyc(1, 0, 0, 0);
    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].ps, tbl[i].tgt, tbl[i].st);
      check($sformatf("tbl%0d_req", i), {31'd0, req1}, {31'd0, tbl[i].req});
      check($sformatf("tbl%0d_addr", i), addr1, tbl[i].addr);
      check_head($sformatf("tbl%0d", i), tbl[i].valid, tbl[i].pc);
    end

    // ---------------- stall from reset: exactly four requests, then drain in order
    cyc(1, 0, 0, 0);
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 1);
      if (req1) begin
        check("stall_req_addr", addr1, 32'(4 * nreq));
        nreq++;
      end
      if (valid1) check("stall_head_pc", pc1, 32'h0);
    end
    check("stall_nreq", 32'(nreq), 32'd4);
    check("stall_full_valid", {31'd0, valid1}, 32'd1);
    for (int j = 0; j < 6; j++) begin
      cyc(0, 0, 0, 0);
      check_head($sformatf("drain%0d", j), 1'b1, 32'(4 * j));
    end

    // ---------------- redirect + stall on a full queue
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);
    check("full_req", {31'd0, req1}, 32'd0);
    cyc(0, 1, 32'h080, 1);
    check("flush_req", {31'd0, req1}, 32'd0);
    check_head("flush_pre", 1'b1, 32'h0);
    cyc(0, 0, 0, 1);
    check_head("flush_t1", 1'b0, 0);
    check("flush_t1_req", {31'd0, req1}, 32'd1);
    check("flush_t1_addr", addr1, 32'h080);
    cyc(0, 0, 0, 1);
    check_head("flush_t2", 1'b0, 0);
    cyc(0, 0, 0, 1);
    check_head("flush_t3", 1'b1, 32'h080);
    cyc(0, 0, 0, 0);
    check_head("flush_t4", 1'b1, 32'h080);
    cyc(0, 0, 0, 0);
    check_head("flush_t5", 1'b1, 32'h084);

    // ---------------- reset with two entries queued and a request in flight
    cyc(1, 0, 0, 0);
    cyc(0, 1, 32'h500, 1);
    cyc(0, 0, 0, 1);
    check("rst_setup_addr", addr1, 32'h500);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    check_head("rst_pre", 1'b1, 32'h500);
    check("rst_req", {31'd0, req1}, 32'd0);
    cyc(0, 0, 0, 0);
    check_head("rst_t1", 1'b0, 0);
    check("rst_t1_addr", addr1, 32'h000);
    cyc(0, 0, 0, 0);
    check_head("rst_t2", 1'b0, 0);
    cyc(0, 0, 0, 0);
    check_head("rst_t3", 1'b1, 32'h000);
    cyc(0, 0, 0, 0);
    check_head("rst_t4", 1'b1, 32'h004);

    // ---------------- PC wrap on the high-reset-PC instance
    cyc(1, 0, 0, 0);
    check("wrap_rst_addr", addr2, 32'hFFFF_FFF8);
    check("wrap_rst_req", {31'd0, req2}, 32'd0);
    cyc(0, 0, 0, 0);
    check("wrap_d0_addr", addr2, 32'hFFFF_FFF8);
    cyc(0, 0, 0, 0);
    check("wrap_d1_addr", addr2, 32'hFFFF_FFFC);
    check("wrap_d1_valid", {31'd0, valid2}, 32'd0);
    cyc(0, 0, 0, 0);
    check("wrap_d2_addr", addr2, 32'h0000_0000);
    check("wrap_d2_pc", pc2, 32'hFFFF_FFF8);
    check("wrap_d2_instr", instr2, 32'hFFFF_FFF8);
    check("wrap_d2_p4", p42, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);
    check("wrap_d3_pc", pc2, 32'hFFFF_FFFC);
    check("wrap_d3_p4", p42, 32'h0000_0000);
    cyc(0, 0, 0, 0);
    check("wrap_d4_pc", pc2, 32'h0000_0000);
    check("wrap_d4_instr", instr2, 32'h0000_A000);
    cyc(0, 0, 0, 0);
    check("wrap_d5_pc", pc2, 32'h0000_0004);
    check("wrap_d5_valid", {31'd0, valid2}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
